// File: rtl/ccu_arbiter.sv
// Round-robin arbiter that shares the single CCU transaction engine between ACE masters.
// One read or write transaction is granted at a time and held until its final handshake.

package ccu_arbiter_pkg;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } ax_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic        last;
  } r_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    ax_chan_t ar;
    logic     ar_valid;
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     r_ready;
    logic     b_ready;
  } ace_req_t;

  typedef struct packed {
    logic    ar_ready;
    logic    aw_ready;
    logic    w_ready;
    r_chan_t r;
    logic    r_valid;
    b_chan_t b;
    logic    b_valid;
  } ace_resp_t;
endpackage

module ccu_arbiter #(
  parameter int unsigned NoMstPorts = 4,
  parameter type mst_req_t  = ccu_arbiter_pkg::ace_req_t,
  parameter type mst_resp_t = ccu_arbiter_pkg::ace_resp_t,
  parameter int unsigned IdxW = (NoMstPorts > 32'd1) ? $clog2(NoMstPorts) : 32'd1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  mst_req_t  [NoMstPorts-1:0]   slv_reqs_i,
  output mst_resp_t [NoMstPorts-1:0]   slv_resps_o,
  output mst_req_t                     ccu_req_o,
  input  mst_resp_t                    ccu_resp_i,
  output logic      [IdxW-1:0]         initiator_o,
  output logic                         busy_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRANT_R = 3'd1,
    DATA_R  = 3'd2,
    GRANT_W = 3'd3,
    DATA_W  = 3'd4
  } state_e;

  state_e          state_q;
  logic [IdxW-1:0] gnt_q;
  logic [IdxW-1:0] rr_q;
  logic            busy_q;

  logic            arb_found_s;
  logic            arb_read_s;
  logic [IdxW-1:0] arb_idx_s;
  mst_req_t        gnt_req_s;

  function automatic logic [IdxW-1:0] wrap_inc(input logic [IdxW-1:0] idx, input int unsigned step);
    return IdxW'((32'(idx) + step) % NoMstPorts);
  endfunction

  assign gnt_req_s   = slv_reqs_i[gnt_q];
  assign initiator_o = gnt_q;
  assign busy_o      = busy_q;

  // Scan from rr_q upward; the first master with any address valid wins, reads before writes.
  always_comb begin
    arb_found_s = 1'b0;
    arb_read_s  = 1'b0;
    arb_idx_s   = '0;
    for (int unsigned k = 0; k < NoMstPorts; k++) begin
      if (!arb_found_s && (slv_reqs_i[wrap_inc(rr_q, k)].ar_valid ||
                           slv_reqs_i[wrap_inc(rr_q, k)].aw_valid)) begin
        arb_found_s = 1'b1;
        arb_idx_s   = wrap_inc(rr_q, k);
        arb_read_s  = slv_reqs_i[wrap_inc(rr_q, k)].ar_valid;
      end else begin
        arb_found_s = arb_found_s;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_found_s) begin
            gnt_q   <= arb_idx_s;
            busy_q  <= 1'b1;
            state_q <= arb_read_s ? GRANT_R : GRANT_W;
          end
        end
        GRANT_R: begin
          if (gnt_req_s.ar_valid && ccu_resp_i.ar_ready) state_q <= DATA_R;
        end
        DATA_R: begin
          if (ccu_resp_i.r_valid && gnt_req_s.r_ready && ccu_resp_i.r.last) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            rr_q    <= wrap_inc(gnt_q, 32'd1);
          end
        end
        GRANT_W: begin
          if (gnt_req_s.aw_valid && ccu_resp_i.aw_ready) state_q <= DATA_W;
        end
        DATA_W: begin
          if (ccu_resp_i.b_valid && gnt_req_s.b_ready) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            rr_q    <= wrap_inc(gnt_q, 32'd1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Only the granted master's channels for the current phase are connected; all else is zero.
  always_comb begin
    ccu_req_o   = '0;
    slv_resps_o = '0;
    case (state_q)
      GRANT_R: begin
        ccu_req_o.ar                = gnt_req_s.ar;
        ccu_req_o.ar_valid          = gnt_req_s.ar_valid;
        slv_resps_o[gnt_q].ar_ready = ccu_resp_i.ar_ready;
      end
      DATA_R: begin
        slv_resps_o[gnt_q].r       = ccu_resp_i.r;
        slv_resps_o[gnt_q].r_valid = ccu_resp_i.r_valid;
        ccu_req_o.r_ready          = gnt_req_s.r_ready;
      end
      GRANT_W: begin
        ccu_req_o.aw                = gnt_req_s.aw;
        ccu_req_o.aw_valid          = gnt_req_s.aw_valid;
        slv_resps_o[gnt_q].aw_ready = ccu_resp_i.aw_ready;
      end
      DATA_W: begin
        ccu_req_o.w                = gnt_req_s.w;
        ccu_req_o.w_valid          = gnt_req_s.w_valid;
        ccu_req_o.b_ready          = gnt_req_s.b_ready;
        slv_resps_o[gnt_q].w_ready = ccu_resp_i.w_ready;
        slv_resps_o[gnt_q].b       = ccu_resp_i.b;
        slv_resps_o[gnt_q].b_valid = ccu_resp_i.b_valid;
      end
      default: begin
        ccu_req_o   = '0;
        slv_resps_o = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_ccu_arbiter.sv
// Randomised bench for ccu_arbiter: bus agents for masters and CCU, a transaction-level
// ownership model checked every cycle, and directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_ccu_arbiter;
  import ccu_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  ace_req_t  [N-1:0]    slv_reqs;
  ace_resp_t [N-1:0]    slv_resps;
  ace_req_t             ccu_req;
  ace_resp_t            ccu_resp;
  logic      [IW-1:0]   initiator;
  logic                 busy;

  int total = 0;
  int bad   = 0;

  ccu_arbiter #(.NoMstPorts(N)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .slv_reqs_i  (slv_reqs),
    .slv_resps_o (slv_resps),
    .ccu_req_o   (ccu_req),
    .ccu_resp_i  (ccu_resp),
    .initiator_o (initiator),
    .busy_o      (busy)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // agent knobs (percent probabilities)
  int ar_rdy_pct = 100, aw_rdy_pct = 100, w_rdy_pct = 100, r_vld_pct = 100, b_vld_pct = 100;
  int r_rdy_pct = 100, w_vld_pct = 100, b_rdy_pct = 100;

  // master agent state
  bit       want_rd [N];
  bit       want_wr [N];
  logic [3:0] want_rd_id [N];
  logic [3:0] want_wr_id [N];
  logic [7:0] want_rd_len [N];
  int       want_wr_beats [N];
  bit       rd_act [N];
  bit       wr_act [N];
  int       w_sent [N];
  int       w_total [N];
  int       r_cnt [N];
  int       b_cnt [N];

  // handshakes sampled at the negedge, consumed by the drivers
  bit m_ar_hs [N], m_aw_hs [N], m_w_hs [N], m_r_hs [N], m_r_last [N], m_b_hs [N];
  bit c_ar_hs, c_aw_hs, c_w_hs, c_w_last, c_r_hs, c_b_hs;
  logic [7:0] c_ar_len;
  logic [3:0] c_ar_id, c_aw_id;

  // CCU agent state
  int         c_r_left = 0;
  logic [3:0] c_r_id, c_b_id;
  bit         c_b_pend = 1'b0;

  // reference model: who owns the engine and which phase it is in
  int  mo_owner = -1;
  bit  mo_read = 1'b0;
  bit  mo_addr_done = 1'b0;
  int  mo_rr = 0;
  bit  prev_busy = 1'b0;
  int  gnt_log[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit pct(input int p);
    return (int'($urandom_range(99)) < p);
  endfunction

  // compare process + model update + handshake sampling
  initial forever begin
    ace_req_t               g;
    ace_req_t               exp_req;
    ace_resp_t [N-1:0]      exp_resp;
    bit                     found;
    int                     c;
    @(negedge clk);
    if (!rst_n) begin
      mo_owner = -1;
      mo_rr = 0;
      prev_busy = 1'b0;
      chk("rst_busy", busy, 1'b0);
      chk("rst_req", ccu_req, '0);
      chk("rst_resps", slv_resps, '0);
      for (int i = 0; i < N; i++) begin
        m_ar_hs[i] = 0; m_aw_hs[i] = 0; m_w_hs[i] = 0; m_r_hs[i] = 0; m_r_last[i] = 0; m_b_hs[i] = 0;
      end
      c_ar_hs = 0; c_aw_hs = 0; c_w_hs = 0; c_w_last = 0; c_r_hs = 0; c_b_hs = 0;
    end else begin
      exp_req  = '0;
      exp_resp = '0;
      g = '0;
      if (mo_owner >= 0) begin
        g = slv_reqs[mo_owner];
        if (mo_read && !mo_addr_done) begin
          exp_req.ar = g.ar; exp_req.ar_valid = g.ar_valid;
          exp_resp[mo_owner].ar_ready = ccu_resp.ar_ready;
        end else if (mo_read) begin
          exp_resp[mo_owner].r = ccu_resp.r; exp_resp[mo_owner].r_valid = ccu_resp.r_valid;
          exp_req.r_ready = g.r_ready;
        end else if (!mo_addr_done) begin
          exp_req.aw = g.aw; exp_req.aw_valid = g.aw_valid;
          exp_resp[mo_owner].aw_ready = ccu_resp.aw_ready;
        end else begin
          exp_req.w = g.w; exp_req.w_valid = g.w_valid; exp_req.b_ready = g.b_ready;
          exp_resp[mo_owner].w_ready = ccu_resp.w_ready;
          exp_resp[mo_owner].b = ccu_resp.b; exp_resp[mo_owner].b_valid = ccu_resp.b_valid;
        end
      end
      chk("ccu_req", ccu_req, exp_req);
      for (int i = 0; i < N; i++) chk($sformatf("resp%0d", i), slv_resps[i], exp_resp[i]);
      chk("busy", busy, (mo_owner >= 0));
      if (mo_owner >= 0) chk("initiator", initiator, mo_owner);

      if (busy && !prev_busy) gnt_log.push_back((ccu_req.ar_valid ? 16 : 0) + int'(initiator));
      prev_busy = busy;

      // model next state
      if (mo_owner < 0) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          c = (mo_rr + k) % N;
          if (!found && (slv_reqs[c].ar_valid || slv_reqs[c].aw_valid)) begin
            found = 1'b1;
            mo_owner = c;
            mo_read = slv_reqs[c].ar_valid;
            mo_addr_done = 1'b0;
          end
        end
      end else if (!mo_addr_done) begin
        if (mo_read ? (g.ar_valid && ccu_resp.ar_ready) : (g.aw_valid && ccu_resp.aw_ready))
          mo_addr_done = 1'b1;
      end else if (mo_read ? (ccu_resp.r_valid && g.r_ready && ccu_resp.r.last)
                           : (ccu_resp.b_valid && g.b_ready)) begin
        mo_rr = (mo_owner + 1) % N;
        mo_owner = -1;
      end

      // handshakes as seen on the actual buses
      for (int i = 0; i < N; i++) begin
        m_ar_hs[i]  = slv_reqs[i].ar_valid && slv_resps[i].ar_ready;
        m_aw_hs[i]  = slv_reqs[i].aw_valid && slv_resps[i].aw_ready;
        m_w_hs[i]   = slv_reqs[i].w_valid && slv_resps[i].w_ready;
        m_r_hs[i]   = slv_resps[i].r_valid && slv_reqs[i].r_ready;
        m_r_last[i] = slv_resps[i].r.last;
        m_b_hs[i]   = slv_resps[i].b_valid && slv_reqs[i].b_ready;
      end
      c_ar_hs = ccu_req.ar_valid && ccu_resp.ar_ready;
      c_ar_len = ccu_req.ar.len; c_ar_id = ccu_req.ar.id;
      c_aw_hs = ccu_req.aw_valid && ccu_resp.aw_ready;
      c_aw_id = ccu_req.aw.id;
      c_w_hs = ccu_req.w_valid && ccu_resp.w_ready;
      c_w_last = ccu_req.w.last;
      c_r_hs = ccu_resp.r_valid && ccu_req.r_ready;
      c_b_hs = ccu_resp.b_valid && ccu_req.b_ready;
    end
  end

  // master and CCU agents, driven just after the rising edge
  initial forever begin
    @(posedge clk); #1;
    if (!rst_n) begin
      slv_reqs = '0; ccu_resp = '0; c_r_left = 0; c_b_pend = 1'b0;
      for (int i = 0; i < N; i++) begin
        want_rd[i] = 0; want_wr[i] = 0; rd_act[i] = 0; wr_act[i] = 0;
        w_sent[i] = 0; w_total[i] = 0; r_cnt[i] = 0; b_cnt[i] = 0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (m_ar_hs[i]) begin slv_reqs[i].ar_valid = 1'b0; rd_act[i] = 1'b1; end
        if (m_r_hs[i]) begin r_cnt[i]++; if (m_r_last[i]) rd_act[i] = 1'b0; end
        if (!slv_reqs[i].ar_valid && !rd_act[i] && want_rd[i]) begin
          want_rd[i] = 1'b0;
          slv_reqs[i].ar_valid = 1'b1;
          slv_reqs[i].ar.id = want_rd_id[i];
          slv_reqs[i].ar.len = want_rd_len[i];
          slv_reqs[i].ar.addr = $urandom;
        end
        slv_reqs[i].r_ready = pct(r_rdy_pct);
        if (m_aw_hs[i]) slv_reqs[i].aw_valid = 1'b0;
        if (m_w_hs[i]) begin slv_reqs[i].w_valid = 1'b0; w_sent[i]++; end
        if (m_b_hs[i]) begin wr_act[i] = 1'b0; b_cnt[i]++; end
        if (!wr_act[i] && want_wr[i]) begin
          want_wr[i] = 1'b0; wr_act[i] = 1'b1;
          slv_reqs[i].aw_valid = 1'b1;
          slv_reqs[i].aw.id = want_wr_id[i];
          slv_reqs[i].aw.len = 8'(want_wr_beats[i] - 1);
          slv_reqs[i].aw.addr = $urandom;
          w_sent[i] = 0; w_total[i] = want_wr_beats[i];
        end
        if (wr_act[i] && !slv_reqs[i].w_valid && w_sent[i] < w_total[i] && pct(w_vld_pct)) begin
          slv_reqs[i].w_valid = 1'b1;
          slv_reqs[i].w.data = $urandom;
          slv_reqs[i].w.last = (w_sent[i] == w_total[i] - 1);
        end
        slv_reqs[i].b_ready = pct(b_rdy_pct);
      end
      if (c_ar_hs) begin c_r_left = int'(c_ar_len) + 1; c_r_id = c_ar_id; end
      if (c_r_hs) begin ccu_resp.r_valid = 1'b0; c_r_left--; end
      if (!ccu_resp.r_valid && c_r_left > 0 && pct(r_vld_pct)) begin
        ccu_resp.r_valid = 1'b1; ccu_resp.r.id = c_r_id;
        ccu_resp.r.data = $urandom; ccu_resp.r.last = (c_r_left == 1);
      end
      ccu_resp.ar_ready = pct(ar_rdy_pct);
      ccu_resp.aw_ready = pct(aw_rdy_pct);
      ccu_resp.w_ready  = pct(w_rdy_pct);
      if (c_aw_hs) c_b_id = c_aw_id;
      if (c_w_hs && c_w_last) c_b_pend = 1'b1;
      if (c_b_hs) ccu_resp.b_valid = 1'b0;
      if (!ccu_resp.b_valid && c_b_pend && pct(b_vld_pct)) begin
        ccu_resp.b_valid = 1'b1; c_b_pend = 1'b0;
        ccu_resp.b.id = c_b_id; ccu_resp.b.resp = 2'($urandom);
      end
    end
  end

  task automatic wait_idle(input string name);
    int n;
    bit quiet;
    n = 0;
    quiet = 1'b0;
    while (!quiet && n < 3000) begin
      @(negedge clk); n++;
      quiet = !busy;
      for (int i = 0; i < N; i++)
        quiet &= !want_rd[i] && !want_wr[i] && !slv_reqs[i].ar_valid && !rd_act[i] && !wr_act[i];
    end
    total++;
    if (!quiet) begin bad++; $display("FAIL %s: not idle after %0d cycles", name, n); end
  endtask

  task automatic issue_rd(input int m, input logic [3:0] id, input logic [7:0] len);
    want_rd_id[m] = id; want_rd_len[m] = len; want_rd[m] = 1'b1;
  endtask

  task automatic issue_wr(input int m, input logic [3:0] id, input int beats);
    want_wr_id[m] = id; want_wr_beats[m] = beats; want_wr[m] = 1'b1;
  endtask

  task automatic all_ready();
    ar_rdy_pct = 100; aw_rdy_pct = 100; w_rdy_pct = 100; r_vld_pct = 100; b_vld_pct = 100;
    r_rdy_pct = 100; w_vld_pct = 100; b_rdy_pct = 100;
  endtask

  initial begin
    int n, snap;
    slv_reqs = '0;
    ccu_resp = '0;
    all_ready();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_initiator", initiator, 0);
    chk("reset_ccu_req", ccu_req, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // single 4-beat read from master 2
    issue_rd(2, 4'd5, 8'd3);
    n = 0;
    while (!slv_reqs[2].ar_valid && n < 20) begin @(negedge clk); n++; end
    chk("t1_idle_no_fwd", ccu_req.ar_valid, 1'b0);
    @(negedge clk);
    chk("t1_ar_valid", ccu_req.ar_valid, 1'b1);
    chk("t1_ar_id", ccu_req.ar.id, 4'd5);
    chk("t1_initiator", initiator, 2'd2);
    wait_idle("t1_idle");
    chk("t1_beats_m2", r_cnt[2], 4);
    chk("t1_beats_other", r_cnt[0] + r_cnt[1] + r_cnt[3], 0);

    // contention right after master 2 finished: rr points at 3
    gnt_log.delete();
    issue_rd(0, 4'd1, 8'd0); issue_rd(1, 4'd2, 8'd0); issue_rd(3, 4'd3, 8'd0);
    wait_idle("t2_idle");
    chk("t2_count", gnt_log.size(), 3);
    chk("t2_g0", gnt_log[0], 16 + 3);
    chk("t2_g1", gnt_log[1], 16 + 0);
    chk("t2_g2", gnt_log[2], 16 + 1);

    // read before write from the same master
    gnt_log.delete();
    issue_rd(1, 4'd7, 8'd1); issue_wr(1, 4'd8, 2);
    wait_idle("t3_idle");
    chk("t3_count", gnt_log.size(), 2);
    chk("t3_first_read", gnt_log[0], 16 + 1);
    chk("t3_then_write", gnt_log[1], 1);

    // write with delayed b_ready
    snap = b_cnt[0];
    b_rdy_pct = 0;
    issue_wr(0, 4'd4, 2);
    n = 0;
    while (!ccu_resp.b_valid && n < 50) begin @(negedge clk); n++; end
    for (int k = 0; k < 3; k++) begin
      chk("t4_busy_hold", busy, 1'b1);
      chk("t4_b_valid_m0", slv_resps[0].b_valid, 1'b1);
      chk("t4_b_valid_m1", slv_resps[1].b_valid, 1'b0);
      @(negedge clk);
    end
    b_rdy_pct = 100;
    wait_idle("t4_idle");
    chk("t4_b_count", b_cnt[0] - snap, 1);

    // AR backpressure then toggling r_ready
    snap = r_cnt[3];
    ar_rdy_pct = 0;
    issue_rd(3, 4'd9, 8'd2);
    n = 0;
    while (!ccu_req.ar_valid && n < 20) begin @(negedge clk); n++; end
    for (int k = 0; k < 5; k++) begin
      chk("t5_ar_id_stable", ccu_req.ar.id, 4'd9);
      chk("t5_ar_len_stable", ccu_req.ar.len, 8'd2);
      chk("t5_no_ar_ready", slv_resps[3].ar_ready, 1'b0);
      @(negedge clk);
    end
    ar_rdy_pct = 100;
    r_rdy_pct = 50;
    wait_idle("t5_idle");
    chk("t5_beats", r_cnt[3] - snap, 3);
    all_ready();

    // reset during beat 2 of a 4-beat read
    snap = r_cnt[1];
    issue_rd(1, 4'd3, 8'd3);
    n = 0;
    while (r_cnt[1] - snap < 1 && n < 30) begin @(negedge clk); n++; end
    #1 rst_n = 1'b0;
    #1;
    chk("t6_busy", busy, 1'b0);
    chk("t6_initiator", initiator, 0);
    chk("t6_ccu_req", ccu_req, '0);
    chk("t6_resps", slv_resps, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    gnt_log.delete();
    issue_rd(0, 4'd1, 8'd0); issue_rd(1, 4'd2, 8'd0); issue_rd(3, 4'd3, 8'd0);
    wait_idle("t6_idle");
    chk("t6_count", gnt_log.size(), 3);
    chk("t6_g0", gnt_log[0], 16 + 0);
    chk("t6_g1", gnt_log[1], 16 + 1);
    chk("t6_g2", gnt_log[2], 16 + 3);

    // random traffic against the model
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 50 == 0) begin
        ar_rdy_pct = $urandom_range(100, 20); aw_rdy_pct = $urandom_range(100, 20);
        w_rdy_pct = $urandom_range(100, 20); r_vld_pct = $urandom_range(100, 20);
        b_vld_pct = $urandom_range(100, 20); r_rdy_pct = $urandom_range(100, 20);
        w_vld_pct = $urandom_range(100, 20); b_rdy_pct = $urandom_range(100, 20);
      end
      for (int m = 0; m < N; m++) begin
        if (!want_rd[m] && $urandom_range(99) < 5) issue_rd(m, 4'($urandom), 8'($urandom_range(7)));
        if (!want_wr[m] && $urandom_range(99) < 5) issue_wr(m, 4'($urandom), int'($urandom_range(4, 1)));
      end
      @(negedge clk);
    end
    all_ready();
    wait_idle("random_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
